// File: rtl/ram_hs_bytemem.sv
// ram_hs_bytemem
//   Byte-addressed, big-endian data/instruction RAM with a registered MOV/MOC
//   four-phase handshake, programmable wait states, signed and unsigned loads
//   and optional alignment trapping.
//
//   Handshake: the control unit raises MOV and holds it until it sees MOC=1.
//   The request (Address, OP, ReadWrite, DataIn) is latched on the edge that
//   accepts MOV in IDLE. MOC stays 1 while MOV stays 1. The first edge that
//   samples MOV=0 in DONE clears MOC/Err and returns to IDLE, so MOV must be
//   low for at least one edge between requests. If MOV drops before MOC, the
//   operation still completes and MOC pulses for one cycle.
//
//   Optional feature macro: RAM_ALIGN_CHECK_EN (misaligned word/half ops are
//   trapped: no access, DataOut unchanged, Err=1 alongside MOC).
//
// Ports
//   Clk        in   1   clock, rising edge
//   Clr        in   1   asynchronous active-low reset
//   MOV        in   1   request valid
//   ReadWrite  in   1   1 = read, 0 = write
//   OP         in   6   load/store opcode
//   Address    in   32  byte address, only [ADDR_W-1:0] used
//   DataIn     in   32  store data
//   DataOut    out  32  registered load result
//   MOC        out  1   registered operation complete
//   Err        out  1   registered misalignment flag
//   dbg_state  out  2   current FSM state (0 IDLE, 1 WAIT, 2 ACCESS, 3 DONE)
module ram_hs_bytemem #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        MOV,
  input  logic        ReadWrite,
  input  logic [5:0]  OP,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        Err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state;
  logic [3:0]          count;
  logic [ADDR_W-1:0]   addr_q;
  logic [5:0]          op_q;
  logic                rw_q;
  logic [31:0]         din_q;

  logic [7:0]          mem [DEPTH];

  // Upper address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^Address[31:ADDR_W];

  assign dbg_state = state;

  // Consecutive byte addresses; ADDR_W-bit arithmetic gives the modulo wrap.
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  assign a0 = addr_q;
  assign a1 = addr_q + ADDR_W'(1);
  assign a2 = addr_q + ADDR_W'(2);
  assign a3 = addr_q + ADDR_W'(3);

  // Opcode decode of the latched request.
  logic  is_load, is_store, is_signed;
  size_t sz;
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    sz        = SZ_B;
    case (op_q)
      OP_LW:  begin is_load  = 1'b1; sz = SZ_W; end
      OP_LH:  begin is_load  = 1'b1; sz = SZ_H; is_signed = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; sz = SZ_H; end
      OP_LB:  begin is_load  = 1'b1; sz = SZ_B; is_signed = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; sz = SZ_B; end
      OP_SW:  begin is_store = 1'b1; sz = SZ_W; end
      OP_SH:  begin is_store = 1'b1; sz = SZ_H; end
      OP_SB:  begin is_store = 1'b1; sz = SZ_B; end
      default: ;
    endcase
  end

  // An opcode only counts when it matches the requested direction.
  logic rd_ok, wr_ok, misalign;
  assign rd_ok = rw_q & is_load;
  assign wr_ok = ~rw_q & is_store;

`ifdef RAM_ALIGN_CHECK_EN
  assign misalign = (rd_ok | wr_ok) &&
                    (((sz == SZ_W) && (addr_q[1:0] != 2'b00)) ||
                     ((sz == SZ_H) && addr_q[0]));
`else
  assign misalign = 1'b0;
`endif

  // Big-endian load formatting.
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] rd_data;
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    rd_data = 32'h0;
    case (sz)
      SZ_W:    rd_data = {b0, b1, b2, b3};
      SZ_H:    rd_data = is_signed ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
      default: rd_data = is_signed ? {{24{b0[7]}}, b0} : {24'h0, b0};
    endcase
  end

  // Memory array is never reset. Reset forces state to IDLE asynchronously,
  // so an aborted request can never reach the write below.
  always_ff @(posedge Clk) begin
    if ((state == ST_ACCESS) && wr_ok && !misalign) begin
      case (sz)
        SZ_W: begin
          mem[a0] <= din_q[31:24];
          mem[a1] <= din_q[23:16];
          mem[a2] <= din_q[15:8];
          mem[a3] <= din_q[7:0];
        end
        SZ_H: begin
          mem[a0] <= din_q[15:8];
          mem[a1] <= din_q[7:0];
        end
        default: mem[a0] <= din_q[7:0];
      endcase
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state   <= ST_IDLE;
      count   <= 4'd0;
      addr_q  <= '0;
      op_q    <= 6'd0;
      rw_q    <= 1'b0;
      din_q   <= 32'h0;
      DataOut <= 32'h0;
      MOC     <= 1'b0;
      Err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MOV) begin
            addr_q <= Address[ADDR_W-1:0];
            op_q   <= OP;
            rw_q   <= ReadWrite;
            din_q  <= DataIn;
            count  <= WAIT_INIT;
            state  <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          count <= count - 4'd1;
          // Leave on the edge where count reaches zero.
          if (count <= 4'd1) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          MOC   <= 1'b1;
          Err   <= misalign;
          state <= ST_DONE;
          // Invalid read opcode returns zero; writes never touch DataOut.
          if (rw_q) begin
            if (!rd_ok)         DataOut <= 32'h0;
            else if (!misalign) DataOut <= rd_data;
          end
        end
        ST_DONE: begin
          if (!MOV) begin
            MOC   <= 1'b0;
            Err   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
